imm_extend_pipe: RTL

Parametrised, pipelined successor to the single-cycle immediate extender. It is intended for the pipelined core's decode stage.
- Decodes I/S/B/J immediates, plus U-type and CSR zero-extended (Z) immediates, to XLEN bits.
- Carries a sideband tag (e.g. PC) alongside each result.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes on both sides, so upstream ready never depends combinationally on downstream ready.

---
 rtl/imm_extend_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: decodes RISC-V I/S/B/J/U/Z immediates to XLEN bits
// and buffers {imm, tag, err} in a 2-entry skid FIFO with valid/ready on both sides.
module imm_extend_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] OutTag,
    output logic             OutErr
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(2);

    logic [XLEN-1:0]  imm_c;
    logic             err_c;
    logic             push_c;
    logic             pop_c;

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             err_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Opcode bits never feed an immediate.
    logic unused_opcode;
    assign unused_opcode = ^Instr[6:0];

    // Immediate decode; sign extension comes from the signed-to-wider casts.
    always_comb begin
        imm_c = '0;
        err_c = 1'b0;
        case (ImmSrc)
            3'b000:  imm_c = XLEN'($signed(Instr[31:20]));
            3'b001:  imm_c = XLEN'($signed({Instr[31:25], Instr[11:7]}));
            3'b010:  imm_c = XLEN'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
            3'b011:  imm_c = XLEN'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
            3'b100:  imm_c = XLEN'($signed({Instr[31:12], 12'h000}));
            3'b101:  imm_c = XLEN'(Instr[19:15]);
            default: err_c = 1'b1;
        endcase
    end

    assign InReady  = (count_q != FULL);
    assign OutValid = (count_q != '0);
    assign ImmExt   = imm_q[rd_ptr_q];
    assign OutTag   = tag_q[rd_ptr_q];
    assign OutErr   = err_q[rd_ptr_q];

    // Flush wins over any push or pop in the same cycle.
    assign push_c = InValid && InReady && !Flush;
    assign pop_c  = OutValid && OutReady && !Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = ~wr_ptr_q;
            if (pop_c)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_c) begin
                imm_q[wr_ptr_q] <= imm_c;
                tag_q[wr_ptr_q] <= InTag;
                err_q[wr_ptr_q] <= err_c;
            end
        end
    end

endmodule
